// File: rtl/win_overlay_pkg.sv
// Shared types and constants for the win banner overlay: window geometry,
// win-state codes and the blink sequencer state encoding.
package win_overlay_pkg;

  localparam logic [9:0] WIN_W = 10'd36;
  localparam logic [9:0] WIN_H = 10'd28;

  localparam logic [2:0] ST_WIN_2 = 3'd2;
  localparam logic [2:0] ST_WIN_3 = 3'd3;
  localparam logic [2:0] ST_WIN_4 = 3'd4;
  localparam logic [2:0] ST_WIN_5 = 3'd5;

  localparam logic [9:0] ORG2_X = 10'd31;
  localparam logic [9:0] ORG2_Y = 10'd103;
  localparam logic [9:0] ORG3_X = 10'd576;
  localparam logic [9:0] ORG3_Y = 10'd240;
  localparam logic [9:0] ORG4_X = 10'd30;
  localparam logic [9:0] ORG4_Y = 10'd240;
  localparam logic [9:0] ORG5_X = 10'd576;
  localparam logic [9:0] ORG5_Y = 10'd103;

  typedef enum logic [1:0] {
    BLINK_IDLE,
    BLINK_ON,
    BLINK_OFF,
    BLINK_SOLID
  } blink_state_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } win_org_t;

  function automatic logic is_win_state(input logic [2:0] s);
    return (s >= ST_WIN_2) && (s <= ST_WIN_5);
  endfunction

  // Non-win states get a zero origin; callers must gate with is_win_state.
  function automatic win_org_t win_origin(input logic [2:0] s);
    win_org_t o;
    o = '0;
    case (s)
      ST_WIN_2: begin o.x = ORG2_X; o.y = ORG2_Y; end
      ST_WIN_3: begin o.x = ORG3_X; o.y = ORG3_Y; end
      ST_WIN_4: begin o.x = ORG4_X; o.y = ORG4_Y; end
      ST_WIN_5: begin o.x = ORG5_X; o.y = ORG5_Y; end
      default:  o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/win_overlay_pipe_blink.sv
// Frame-counted blink sequencer: ON/OFF phases of BLINK_FRAMES frames, then solid.
// Updates only on frame_start, so show is stable across the active area; no backpressure.
module win_blink_fsm
  import win_overlay_pkg::*;
#(
  parameter int unsigned BLINK_FRAMES  = 30,
  parameter int unsigned BLINK_TOGGLES = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic [2:0] game_state,
  input  logic [2:0] state_q,
  output logic       show
);

  localparam logic [5:0] FRAMES_M1 = 6'(BLINK_FRAMES - 1);
  localparam logic [2:0] TOGGLES   = 3'(BLINK_TOGGLES);

  blink_state_t st, st_nxt;
  logic [5:0]   fcnt, fcnt_nxt;
  logic [2:0]   tcnt, tcnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= BLINK_IDLE;
      fcnt <= '0;
      tcnt <= '0;
    end else begin
      st   <= st_nxt;
      fcnt <= fcnt_nxt;
      tcnt <= tcnt_nxt;
    end
  end

  always_comb begin
    st_nxt   = st;
    fcnt_nxt = fcnt;
    tcnt_nxt = tcnt;
    if (frame_start) begin
      // A state change always restarts the sequence, even win-to-win.
      if (game_state != state_q) begin
        fcnt_nxt = '0;
        tcnt_nxt = '0;
        st_nxt   = is_win_state(game_state) ? BLINK_ON : BLINK_IDLE;
      end else begin
        case (st)
          BLINK_IDLE: begin
            if (is_win_state(game_state)) begin
              st_nxt   = BLINK_ON;
              fcnt_nxt = '0;
              tcnt_nxt = '0;
            end
          end
          BLINK_ON, BLINK_OFF: begin
            if (fcnt == FRAMES_M1) begin
              fcnt_nxt = '0;
              tcnt_nxt = tcnt + 3'd1;
              if (tcnt_nxt == TOGGLES) st_nxt = BLINK_SOLID;
              else                     st_nxt = (st == BLINK_ON) ? BLINK_OFF : BLINK_ON;
            end else begin
              fcnt_nxt = fcnt + 6'd1;
            end
          end
          default: st_nxt = st;
        endcase
      end
    end
  end

  assign show = (st == BLINK_ON) || (st == BLINK_SOLID);

endmodule

// File: rtl/win_overlay_pipe.sv
// Composites the 36x28 win banner over the background pixel stream.
// Fixed 2-cycle latency, 1 pixel/cycle, no stalls and no backpressure.
module win_overlay_pipe
  import win_overlay_pkg::*;
#(
  parameter int unsigned BLINK_FRAMES  = 30,
  parameter int unsigned BLINK_TOGGLES = 6,
  parameter logic [23:0] KEY_RGB       = 24'hFF00FF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  game_state,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic [23:0] bg_rgb,
  output logic [2:0]  xlat_start,
  output logic [9:0]  xlat_x,
  output logic [9:0]  xlat_y,
  input  logic [16:0] xlat_addr,
  output logic [16:0] rom_addr,
  input  logic [23:0] rom_q,
  output logic        out_valid,
  output logic [23:0] out_rgb
);

  logic [2:0]  state_q;
  logic        show;
  logic        hit;
  win_org_t    org;
  logic        valid1;
  logic        hit1;
  logic [23:0] bg1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           state_q <= '0;
    else if (frame_start) state_q <= game_state;
  end

  assign xlat_start = state_q;
  assign xlat_x     = pix_x;
  assign xlat_y     = pix_y;
  assign rom_addr   = xlat_addr;

  // Hit is decided from geometry, never from the translator address.
  assign org = win_origin(state_q);
  assign hit = is_win_state(state_q)
             && (pix_x >= org.x) && (pix_x < org.x + WIN_W)
             && (pix_y >= org.y) && (pix_y < org.y + WIN_H);

  win_blink_fsm #(
    .BLINK_FRAMES (BLINK_FRAMES),
    .BLINK_TOGGLES(BLINK_TOGGLES)
  ) u_blink (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .game_state (game_state),
    .state_q    (state_q),
    .show       (show)
  );

  // Stage 1 lines up with the ROM's one-cycle read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid1 <= 1'b0;
      hit1   <= 1'b0;
      bg1    <= '0;
    end else begin
      valid1 <= pix_valid;
      hit1   <= hit;
      bg1    <= bg_rgb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_rgb   <= '0;
    end else begin
      out_valid <= valid1;
      if (!valid1)                                 out_rgb <= '0;
      else if (hit1 && show && (rom_q != KEY_RGB)) out_rgb <= rom_q;
      else                                         out_rgb <= bg1;
    end
  end

endmodule

// File: doc/win_overlay_pipe.md
# win_overlay_pipe

Pixel-pipeline stage that composites the 36x28 "win" banner sprite over the background stream feeding the VGA DAC. It sits downstream of `win_address_translator`: it drives the translator's `start`/`x`/`y`, forwards the resulting `mem_address` to the synchronous banner ROM, and aligns the ROM data with the delayed background pixel. It also latches the game state once per frame and runs a frame-counted blink sequence for the banner.

## Interface
- `BLINK_FRAMES`, 30: frames per on/off phase (1..63).
- `BLINK_TOGGLES`, 6: phase changes before the banner goes solid (1..7).
- `KEY_RGB`, 24'hFF00FF: transparent colour in ROM data.

- `clk` in 1: pixel clock.
- `rst_n` in 1: asynchronous reset, active-low.
- `game_state` in 3: live game state; win codes are 2..5.
- `frame_start` in 1: one-cycle pulse during vertical blanking.
- `pix_valid` in 1: active-area pixel qualifier.
- `pix_x` in 10: pixel x coordinate.
- `pix_y` in 10: pixel y coordinate.
- `bg_rgb` in 24: background colour for (`pix_x`, `pix_y`).
- `xlat_start` out 3: to translator `start` (= latched state).
- `xlat_x`, `xlat_y` out 10 each: to translator (= `pix_x`, `pix_y`, combinational).
- `xlat_addr` in 17: translator `mem_address`.
- `rom_addr` out 17: to ROM (= `xlat_addr`, combinational).
- `rom_q` in 24: ROM data, valid exactly 1 cycle after `rom_addr`.
- `out_valid` out 1: composited pixel valid.
- `out_rgb` out 24: composited colour.

## Operation
- State latch: on a cycle with `frame_start`=1, `state_q` <= `game_state`. `xlat_start` = `state_q`. A pixel presented in the same cycle uses the old `state_q`.
- Window hit: computed combinationally from `state_q`, `pix_x`, `pix_y`, using the package window origins. The four windows are:
  - 2 -> (31,103)
  - 3 -> (576,240)
  - 4 -> (30,240)
  - 5 -> (576,103)
  - Each window is 36 wide x 28 tall, and the x/y bounds are half-open.
  - Hit is 0 for any other state. Address 0 alone does not imply a hit.
- Stage 1 registers: `valid1`, `hit1`, `bg1`.
- Stage 2 registers:
  - `out_valid` <= `valid1`.
  - `out_rgb` <= `rom_q` if `hit1` && `show` && `rom_q` != `KEY_RGB`; otherwise `bg1`.
  - When `valid1`=0, `out_rgb` <= 0.
- Blink FSM. Frame and toggle counters advance only on `frame_start`. States:
  - IDLE: `show`=0. Moves to ON on `frame_start` when the new state is 2..5.
  - ON: `show`=1.
  - OFF: `show`=0.
  - SOLID: `show`=1.
- Blink counting:
  - In ON or OFF, `fcnt` counts frames. When `fcnt` reaches `BLINK_FRAMES`-1, `fcnt` <= 0 and `tcnt` increments.
  - The FSM then toggles ON<->OFF. When `tcnt` reaches `BLINK_TOGGLES`, it goes to SOLID.
- On any `frame_start` where the new state differs from `state_q`:
  - If the new state is a win code: enter ON with `fcnt`=`tcnt`=0 (this restarts the sequence, including a 2->3 change).
  - Otherwise: enter IDLE.
- Reset (mid-frame allowed):
  - `state_q`=0, FSM=IDLE, `fcnt`=`tcnt`=0.
  - `valid1`=`hit1`=0, `bg1`=0.
  - `out_valid`=0, `out_rgb`=0.

## Timing
- Latency from pixel in to `out_valid`/`out_rgb` is fixed at 2 cycles. Throughput is 1 pixel/cycle with no stalls and no backpressure.
- `rom_addr` is combinational from `pix_x`/`pix_y` via the translator. The ROM registers the address internally and returns `rom_q` in cycle +1, aligned with stage 1.
- `show` changes only at a `frame_start` edge, so it never changes within the active area.
- Arithmetic: `fcnt` is 6 bits and `tcnt` is 3 bits; neither wraps past its terminal value. Window compares are 10-bit unsigned.

## Structure
- Package `win_overlay_pkg`:
  - Window origin constants per state code.
  - `WIN_W`=36, `WIN_H`=28.
  - Win-state codes.
  - FSM enum `blink_state_t`.
- Sub-module `win_blink_fsm`: frame counter, toggle counter and FSM; outputs `show`.
- The translator is instantiated by the parent, not inside this block.

## Test plan
- State 2 latched, pixel (31,103) valid, `rom_q`=24'h123456 -> `rom_addr`=0; 2 cycles later `out_valid`=1, `out_rgb`=24'h123456.
- State 2, pixel (66,130) -> `rom_addr`=1007. Pixel (67,130) or (30,103) -> `out_rgb`=`bg_rgb`.
- State 3, pixel (576,240), `rom_q`=`KEY_RGB`, `bg_rgb`=24'h0000AA -> `out_rgb`=24'h0000AA.
- `BLINK_FRAMES`=2, `BLINK_TOGGLES`=3, state 4 from frame 0:
  - Frames 0-1 shown, 2-3 hidden, 4-5 shown, then SOLID.
  - Changing to state 5 restarts at ON.
  - Changing to state 0 -> IDLE, banner never shown.
- `game_state` changed mid-frame without `frame_start` -> output unchanged until the next `frame_start`.
- `rst_n` low mid-line with `out_valid`=1 -> `out_valid`=0 and `out_rgb`=0 immediately (asynchronous); FSM=IDLE.
